// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversampled pins, MOSI deserialiser, MSB-first MISO serialiser.
// Define SPI_SLAVE_TX_FIFO_EN to replace the single TX holding register with a FIFO_DEPTH-entry FIFO.
module spi_slave_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_slave_responder: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sclk_s, mosi_s, ssn_s, sclk_rise, sclk_fall;
  logic                   load_pop, tx_push;
  logic [DATA_W-1:0]      load_word;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // A deselect during LOAD must leave the stored word in place.
  assign load_pop  = (state_q == LOAD) && !ssn_s;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        tx_shift_d = '0;
        if (ssn_s) armed_d = 1'b1;
        else if (armed_q) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = load_word;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = LOAD;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CW'(1);
        end else if (sclk_fall && bit_cnt_q != '0) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && ssn_s) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      tx_shift_d = '0;
    end
  end

`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign load_word  = fifo_empty ? '0 : fifo_q[rd_ptr_q[AW-1:0]];
  // The head leaves in the LOAD cycle, so a full FIFO can still take a word then.
  assign tx_ready   = !fifo_full || (load_pop && !fifo_empty);
  assign tx_push    = tx_valid && tx_ready;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (load_pop && !fifo_empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (tx_push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = tx_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    fifo_q <= fifo_d;
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  assign load_word = hold_full_q ? hold_q : '0;
  assign tx_ready  = !hold_full_q;
  assign tx_push   = tx_valid && tx_ready;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_pop) hold_full_d = 1'b0;
    if (tx_push) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    hold_q <= hold_d;
    if (Reset) hold_full_q <= 1'b0;
    else       hold_full_q <= hold_full_d;
  end
`endif

  always_ff @(posedge Clk) begin
    mosi_sync_q <= mosi_sync_d;
    rx_shift_q  <= rx_shift_d;
  end

  // ss_n synchroniser clears to "selected" so a select held across Reset is not honoured.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sclk_sync_q <= '0;
      ssn_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_sync_q <= sclk_sync_d;
      ssn_sync_q  <= ssn_sync_d;
      sclk_prev_q <= sclk_prev_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spi_miso = tx_shift_q[DATA_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed and random SPI frames against a queue-based reference model.
module tb_spi_slave_responder;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FD = 4;
`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int CAP = FD;
`else
  localparam int CAP = 1;
`endif

  logic          Clk, Reset, spi_sclk, spi_mosi, spi_ss_n, spi_miso;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ack, overrun, busy;

  spi_slave_responder #(.DATA_W(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .Reset(Reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .overrun(overrun), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [DW-1:0] txq [$];
  logic [DW-1:0] m_rx_data;
  bit            m_rx_valid, m_ovr;
  logic [DW-1:0] cur_tx;
  logic [DW-1:0] fw [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic model_pop();
    if (txq.size() > 0) cur_tx = txq.pop_front();
    else                cur_tx = '0;
  endtask

  task automatic model_reset();
    txq.delete();
    m_rx_data  = '0;
    m_rx_valid = 0;
    m_ovr      = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     32'(spi_miso), 32'(0));
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'(1));
    chk({tag, "_rx_data"},  32'(rx_data),  32'(0));
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(0));
    chk({tag, "_overrun"},  32'(overrun),  32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    model_reset();
    cyc(4);
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit exp_ready;
    exp_ready = (txq.size() < CAP);
    tx_data   = d;
    tx_valid  = 1'b1;
    chk("tx_ready_push", 32'(tx_ready), 32'(exp_ready));
    cyc(1);
    tx_valid  = 1'b0;
    if (exp_ready) txq.push_back(d);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    cyc(1);
    rx_ack     = 1'b0;
    m_rx_valid = 0;
    m_ovr      = 0;
    chk("ack_rx_valid", 32'(rx_valid), 32'(0));
    chk("ack_overrun",  32'(overrun),  32'(0));
  endtask

  // One SCLK period (5 Clk low, 5 Clk high); master samples MISO just before the rising edge.
  task automatic sbit(input logic mb, input logic exp_m, input bit live);
    spi_mosi = mb;
    cyc(5);
    if (live) begin
      chk("miso_bit", 32'(spi_miso), 32'(exp_m));
      chk("tx_ready_frame", 32'(tx_ready), 32'(txq.size() < CAP));
    end
    spi_sclk = 1'b1;
    cyc(5);
    spi_sclk = 1'b0;
  endtask

  task automatic frame(input int nbits);
    int wi, bi;
    spi_ss_n = 1'b0;
    cyc(8);
    chk("busy_sel", 32'(busy), 32'(1));
    model_pop();
    for (int b = 0; b < nbits; b++) begin
      wi = b / DW;
      bi = DW - 1 - (b % DW);
      sbit(fw[wi][bi], cur_tx[bi], 1);
      if ((b % DW) == DW - 1) begin
        if (m_rx_valid) m_ovr = 1;
        m_rx_valid = 1;
        m_rx_data  = fw[wi];
        model_pop();
      end
    end
    cyc(5);
    spi_ss_n = 1'b1;
    cyc(SS + 1);
    chk("busy_desel", 32'(busy),     32'(0));
    chk("miso_desel", 32'(spi_miso), 32'(0));
    chk("rx_valid",   32'(rx_valid), 32'(m_rx_valid));
    chk("rx_data",    32'(rx_data),  32'(m_rx_data));
    chk("overrun",    32'(overrun),  32'(m_ovr));
    cyc(2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nbits, np;
    Reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
    model_reset();
    cyc(2);
    do_reset();
    chk_reset_vals("rst");

    // Preloaded exchange
    push(8'hA5);
    fw[0] = 8'h3C;
    frame(8);
    ack();

    // Two words in one frame without ack
    fw[0] = 8'h01; fw[1] = 8'h02;
    frame(16);
    ack();

    // Nothing preloaded
    fw[0] = 8'hFF;
    frame(8);
    ack();

    // Aborted frame, then a full one
    fw[0] = 8'hC3;
    frame(5);
    fw[0] = 8'h5A;
    frame(8);
    ack();

    // Reset mid-frame with ss_n held low
    push(8'h99);
    spi_ss_n = 1'b0;
    cyc(8);
    model_pop();
    for (int b = 0; b < 3; b++) sbit(1'b1, cur_tx[DW-1-b], 1);
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    model_reset();
    cyc(1);
    chk_reset_vals("midrst");
    for (int b = 0; b < 5; b++) begin
      sbit(1'b0, 1'b0, 0);
      chk("midrst_busy", 32'(busy),     32'(0));
      chk("midrst_miso", 32'(spi_miso), 32'(0));
    end
    spi_ss_n = 1'b1;
    cyc(4);
    push(8'h7E);
    fw[0] = 8'h81;
    frame(8);
    ack();

    // Fill TX storage, then a 5-word frame drains it
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("tx_ready_full", 32'(tx_ready), 32'(txq.size() < CAP));
    push(8'h55);
    for (int i = 0; i < 5; i++) fw[i] = 8'($urandom);
    frame(40);
    ack();

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      np = $urandom_range(0, CAP + 1);
      for (int k = 0; k < np; k++) push(8'($urandom));
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) fw[i] = 8'($urandom);
      nbits = nw * DW;
      if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, DW - 1);
      frame(nbits);
      if ($urandom_range(0, 1) == 1) ack();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
